fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_sequencer_if.sv | 27 ++
 rtl/fetch_timeout_counter.sv | 39 +++
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Clear the byte-offset bits so an address points at a whole word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory handshake plus the decode hand-off.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  // Sequencer side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
    input  imem_ack, imem_rdata, stall_d, redirect_valid, redirect_target
  );

  // Memory/decode environment side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
    output imem_ack, imem_rdata, stall_d, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles spent waiting for imem_ack and flags the cycle
// in which the wait budget runs out.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q, count_d;

  // Clear wins; otherwise advance once per waiting cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The waiting cycle that would make the count reach the budget.
  assign expired_o = inc_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding read, redirect tracking
// while a read is in flight, and a sticky fault on memory timeout.
//
// state   | meaning
// BOOT    | one cycle after reset, loads the boot PC
// FETCH   | request outstanding at pc, waiting for imem_ack
// PRESENT | instruction held for decode until consumed or redirected
// FAULT   | memory never answered; parked until reset
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         starting_addr,
  fetch_sequencer_if.master   bus,
  output logic                imem_timeout,
  output logic                addr_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         misalign_q, misalign_d;

  logic         in_fetch;
  logic         redirect_taken;
  logic [31:0]  redirect_word;
  logic         cnt_clear;
  logic         cnt_inc;
  logic         cnt_expired;

  assign in_fetch       = (state_q == ST_FETCH);
  assign redirect_taken = bus.redirect_valid &&
                          ((state_q == ST_FETCH) || (state_q == ST_PRESENT));
  assign redirect_word  = align_word(bus.redirect_target);

  // Wait counter restarts whenever we are not waiting or the wait ends.
  assign cnt_clear = !in_fetch || bus.imem_ack;
  assign cnt_inc   = in_fetch && !bus.imem_ack;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (cnt_clear),
    .inc_i     (cnt_inc),
    .expired_o (cnt_expired)
  );

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    pc_plus4_d   = pc_plus4_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    misalign_d   = misalign_q |
                   (redirect_taken && (bus.redirect_target[1:0] != 2'b00));

    case (state_q)
      ST_BOOT: begin
        pc_d    = align_word(starting_addr);
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.imem_ack) begin
          // A redirect in the ack cycle is newer than any pending one.
          if (bus.redirect_valid) begin
            pc_d         = redirect_word;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_tgt_q;
            pend_valid_d = 1'b0;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_plus4_d = pc_q + INSTR_BYTES;
            pc_d       = pc_q + INSTR_BYTES;
            state_d    = ST_PRESENT;
          end
        end else begin
          // Address must stay stable until ack, so only remember the redirect.
          if (bus.redirect_valid) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = redirect_word;
          end
          if (cnt_expired) begin
            state_d = ST_FAULT;
          end
        end
      end

      ST_PRESENT: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_word;
          state_d = ST_FETCH;
        end else if (!bus.stall_d) begin
          state_d = ST_FETCH;
        end
      end

      ST_FAULT: begin
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      pc_plus4_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      pc_plus4_q   <= pc_plus4_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.imem_req    = in_fetch;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ST_PRESENT);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign imem_timeout    = (state_q == ST_FAULT);
  assign addr_misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] start_addr;
  logic        imem_timeout;
  logic        addr_misalign;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_sequencer_if bus();

  fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clock         (clk),
    .reset_n       (rst_n),
    .starting_addr (start_addr),
    .bus           (bus),
    .imem_timeout  (imem_timeout),
    .addr_misalign (addr_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = '0;
    bus.stall_d         = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
  endtask

  task automatic do_reset(input logic [31:0] a);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    start_addr = a;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    start_addr = 32'h00400000;
    #2;
    tests_run++;
    if ({bus.imem_req, bus.instr_valid, imem_timeout, addr_misalign} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got req=%b valid=%b to=%b mis=%b expected all 0",
               bus.imem_req, bus.instr_valid, imem_timeout, addr_misalign);
    end
    tests_run++;
    if ({bus.imem_addr, bus.instr, bus.instr_pc, bus.pc_plus4} !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_data got addr=%h instr=%h ipc=%h p4=%h expected 0",
               bus.imem_addr, bus.instr, bus.instr_pc, bus.pc_plus4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_no_req got req=%b expected 0", bus.imem_req);
    end
    @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00400000) begin
      tests_failed++;
      $display("FAIL first_req got req=%b addr=%h expected 1 00400000",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_boot_sequence();
    bit ok;
    logic [31:0] exp_pc, d;
    do_reset(32'h00400000);
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h00400000 + 32'(4 * k);
      wait_req(4, ok);
      tests_run++;
      if (!ok || bus.imem_addr !== exp_pc) begin
        tests_failed++;
        $display("FAIL boot_req%0d got ok=%b addr=%h expected addr=%h", k, ok, bus.imem_addr, exp_pc);
      end
      @(negedge clk);
      tests_run++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
        tests_failed++;
        $display("FAIL boot_stable%0d got req=%b addr=%h expected 1 %h", k, bus.imem_req, bus.imem_addr, exp_pc);
      end
      d = $urandom;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = d;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      tests_run++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.instr_pc !== exp_pc ||
          bus.pc_plus4 !== exp_pc + 32'd4) begin
        tests_failed++;
        $display("FAIL boot_present%0d got v=%b instr=%h ipc=%h p4=%h expected 1 %h %h %h",
                 k, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus4, d, exp_pc, exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] d;
    do_reset(32'h00400000);
    wait_req(4, ok);
    d = $urandom;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    bus.stall_d    = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== d ||
          bus.instr_pc !== 32'h00400000) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got v=%b req=%b instr=%h ipc=%h expected 1 0 %h 00400000",
                 k, bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc, d);
      end
    end
    bus.stall_d = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00400004 || bus.instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release got req=%b addr=%h v=%b expected 1 00400004 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_redirect_pending();
    bit ok;
    logic [31:0] d;
    do_reset(32'h00400010);
    wait_req(4, ok);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h00400100;
    @(negedge clk);
    bus.redirect_target = 32'h00400200;
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00400010) begin
      tests_failed++;
      $display("FAIL pend_stable1 got req=%b addr=%h expected 1 00400010", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.imem_ack       = 1'b1;
    bus.imem_rdata     = 32'hDEADBEEF;
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00400010) begin
      tests_failed++;
      $display("FAIL pend_stable2 got req=%b addr=%h expected 1 00400010", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    bus.imem_ack = 1'b0;
    tests_run++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00400200) begin
      tests_failed++;
      $display("FAIL pend_discard got v=%b req=%b addr=%h expected 0 1 00400200",
               bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    d = $urandom;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.instr_pc !== 32'h00400200 ||
        addr_misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_cleared got v=%b instr=%h ipc=%h mis=%b expected 1 %h 00400200 0",
               bus.instr_valid, bus.instr, bus.instr_pc, addr_misalign, d);
    end
  endtask

  task automatic test_ack_with_redirect();
    bit ok;
    logic [31:0] d;
    do_reset(32'h00400000);
    wait_req(4, ok);
    bus.imem_ack        = 1'b1;
    bus.imem_rdata      = $urandom;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h00401003;
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00401000 ||
        addr_misalign !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_redir got v=%b req=%b addr=%h mis=%b expected 0 1 00401000 1",
               bus.instr_valid, bus.imem_req, bus.imem_addr, addr_misalign);
    end
    d = $urandom;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h00401000 || addr_misalign !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_sticky got v=%b ipc=%h mis=%b expected 1 00401000 1",
               bus.instr_valid, bus.instr_pc, addr_misalign);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] d;
    do_reset(32'hFFFFFFFE);
    wait_req(4, ok);
    tests_run++;
    if (!ok || bus.imem_addr !== 32'hFFFFFFFC) begin
      tests_failed++;
      $display("FAIL wrap_boot got ok=%b addr=%h expected fffffffc", ok, bus.imem_addr);
    end
    d = $urandom;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    tests_run++;
    if (bus.instr_pc !== 32'hFFFFFFFC || bus.pc_plus4 !== 32'h0 || addr_misalign !== 1'b0 ||
        imem_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_present got ipc=%h p4=%h mis=%b to=%b expected fffffffc 0 0 0",
               bus.instr_pc, bus.pc_plus4, addr_misalign, imem_timeout);
    end
    @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_next got req=%b addr=%h expected 1 0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit m_wait, m_mis, pend, redir, ack, stall;
    logic [31:0] m_addr, m_instr, m_ipc, pend_tgt, tgt, data, s;
    int wait_cnt;
    s = $urandom;
    do_reset(s);
    wait_req(4, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rnd_start got no req expected req");
    end
    m_wait = 1'b1; m_mis = 1'b0; pend = 1'b0; wait_cnt = 0;
    m_addr = s & ~32'd3; m_instr = '0; m_ipc = '0; pend_tgt = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tests_run++;
      if (bus.imem_req !== m_wait || bus.instr_valid !== !m_wait || addr_misalign !== m_mis ||
          imem_timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL rnd_ctrl cyc=%0d got req=%b v=%b mis=%b to=%b expected %b %b %b 0",
                 cyc, bus.imem_req, bus.instr_valid, addr_misalign, imem_timeout, m_wait, !m_wait, m_mis);
      end
      tests_run++;
      if (m_wait) begin
        if (bus.imem_addr !== m_addr) begin
          tests_failed++;
          $display("FAIL rnd_addr cyc=%0d got %h expected %h", cyc, bus.imem_addr, m_addr);
        end
      end else if ({bus.instr, bus.instr_pc, bus.pc_plus4} !== {m_instr, m_ipc, m_ipc + 32'd4}) begin
        tests_failed++;
        $display("FAIL rnd_instr cyc=%0d got %h %h %h expected %h %h %h", cyc,
                 bus.instr, bus.instr_pc, bus.pc_plus4, m_instr, m_ipc, m_ipc + 32'd4);
      end
      redir = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = 32'hFFFFFFFC;
        1:       tgt = $urandom;
        default: tgt = $urandom & ~32'd3;
      endcase
      stall = 1'($urandom_range(0, 1));
      ack   = m_wait ? ((wait_cnt == 3) || ($urandom_range(0, 2) == 0)) : ($urandom_range(0, 3) == 0);
      data  = $urandom;
      bus.redirect_valid  = redir;
      bus.redirect_target = tgt;
      bus.stall_d         = stall;
      bus.imem_ack        = ack;
      bus.imem_rdata      = data;
      if (redir && tgt[1:0] != 2'b00) m_mis = 1'b1;
      if (m_wait) begin
        if (ack) begin
          wait_cnt = 0;
          if (redir) begin
            m_addr = tgt & ~32'd3; pend = 1'b0;
          end else if (pend) begin
            m_addr = pend_tgt; pend = 1'b0;
          end else begin
            m_instr = data; m_ipc = m_addr; m_addr = m_addr + 32'd4; m_wait = 1'b0;
          end
        end else begin
          wait_cnt++;
          if (redir) begin
            pend = 1'b1; pend_tgt = tgt & ~32'd3;
          end
        end
      end else if (redir) begin
        m_addr = tgt & ~32'd3; m_wait = 1'b1; wait_cnt = 0;
      end else if (!stall) begin
        m_wait = 1'b1; wait_cnt = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset(32'h00001000);
    wait_req(4, ok);
    n = ok ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) n++;
      else break;
    end
    tests_run++;
    if (n != 4 || imem_timeout !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_enter got fetch_cycles=%0d to=%b req=%b v=%b expected 4 1 0 0",
               n, imem_timeout, bus.imem_req, bus.instr_valid);
    end
    bus.imem_ack        = 1'b1;
    bus.imem_rdata      = $urandom;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h00002000;
    repeat (5) @(negedge clk);
    idle_inputs();
    tests_run++;
    if (imem_timeout !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
        bus.imem_addr !== 32'h00001000) begin
      tests_failed++;
      $display("FAIL timeout_sticky got to=%b req=%b v=%b addr=%h expected 1 0 0 00001000",
               imem_timeout, bus.imem_req, bus.instr_valid, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_request();
    bit ok;
    do_reset(32'h00400000);
    wait_req(4, ok);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h12345678;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    #2;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFEF00D;
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.imem_req, bus.instr_valid, imem_timeout, addr_misalign} !== 4'b0000 ||
        {bus.imem_addr, bus.instr, bus.instr_pc, bus.pc_plus4} !== 128'd0) begin
      tests_failed++;
      $display("FAIL async_reset got req=%b v=%b addr=%h instr=%h ipc=%h p4=%h expected all 0",
               bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc, bus.pc_plus4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00400000 || bus.instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_restart got req=%b addr=%h v=%b expected 1 00400000 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_stall();
    test_redirect_pending();
    test_ack_with_redirect();
    test_wrap();
    test_random();
    test_timeout();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
